// File: rtl/board_state_mem_pkg.sv
// Shared codes for the macro-board state memory: per-cell state values and
// the clear/idle controller encoding.
package board_state_mem_pkg;

  localparam logic [1:0] ST_RUN = 2'b00;
  localparam logic [1:0] ST_P1  = 2'b01;
  localparam logic [1:0] ST_P2  = 2'b10;
  localparam logic [1:0] ST_TIE = 2'b11;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/board_state_counter.sv
// Running count of cells holding one particular non-running state code.
// A write that replaces one code with another decrements one counter and
// increments another in the same cycle; both strobes together cancel out.
module board_state_counter #(
  parameter int CNT_W = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  // Count update; the bounds guards keep a corrupted strobe from wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != MAX_V)) begin
      cnt <= cnt + ONE;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/board_state_mem.sv
// Macro-board state memory: one 2-bit state per cell at addresses 1..CELLS,
// a sequenced clear, and running per-state counters so the game FSM can
// judge the board (and whether it is finished) without scanning it.
module board_state_mem
  import board_state_mem_pkg::*;
#(
  parameter int CELLS  = 9,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = $clog2(CELLS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic [1:0]        data,
  input  logic [ADDR_W-1:0] addr,
  output logic [1:0]        q,
  output logic              busy,
  output logic [CNT_W-1:0]  n_p1,
  output logic [CNT_W-1:0]  n_p2,
  output logic [CNT_W-1:0]  n_tie,
  output logic              done
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam int                TW    = CNT_W + 2;
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS);

  fsm_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic              busy_r;
  logic [ADDR_W-1:0] addr_p1;
  logic [1:0]        mem [DEPTH];

  logic              restart;
  logic              addr_ok;
  logic              wr_ok;
  logic              clr_step;
  logic [1:0]        old_st;
  logic [CNT_W-1:0]  cnt [3];
  logic [TW-1:0]     total;

  // Reset and clear share one path; either restarts the clear sequence.
  assign restart  = reset | clear;
  assign addr_ok  = (addr >= FIRST) && (addr <= LAST);
  assign wr_ok    = (state == S_IDLE) && we && !restart && addr_ok;
  assign clr_step = (state == S_CLEAR) && !restart;
  assign old_st   = mem[addr];

  // Controller: walk ptr over 1..CELLS zeroing cells, then go idle.
  always_ff @(posedge clk) begin
    if (restart) begin
      state  <= S_CLEAR;
      ptr    <= FIRST;
      busy_r <= 1'b1;
    end else if (state == S_CLEAR) begin
      ptr <= ptr + FIRST;
      if (ptr == LAST) begin
        state  <= S_IDLE;
        busy_r <= 1'b0;
      end
    end
  end

  // Storage: sequenced clear has the port while busy, host writes otherwise.
  always_ff @(posedge clk) begin
    if (clr_step) begin
      mem[ptr] <= ST_RUN;
    end else if (wr_ok) begin
      mem[addr] <= data;
    end
  end

  // Stage p1: registered read address.
  always_ff @(posedge clk) begin
    if (restart) begin
      addr_p1 <= '0;
    end else begin
      addr_p1 <= addr;
    end
  end

  // Read data; reserved/out-of-range addresses and the clear window read 00.
  always_comb begin
    q = ST_RUN;
    if (!busy_r && (addr_p1 >= FIRST) && (addr_p1 <= LAST)) begin
      q = mem[addr_p1];
    end
  end

  // One counter per non-running code: leaving code c decrements, entering increments.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    localparam logic [1:0] CODE = 2'(gi + 1);
    board_state_counter #(
      .CNT_W (CNT_W),
      .MAX   (CELLS)
    ) u_cnt (
      .clk (clk),
      .clr (restart),
      .inc (wr_ok && (data == CODE) && (old_st != CODE)),
      .dec (wr_ok && (old_st == CODE) && (data != CODE)),
      .cnt (cnt[gi])
    );
  end

  assign n_p1  = cnt[0];
  assign n_p2  = cnt[1];
  assign n_tie = cnt[2];
  assign busy  = busy_r;

  // Board finished when every cell is decided.
  assign total = TW'(n_p1) + TW'(n_p2) + TW'(n_tie);
  assign done  = (total == TW'(CELLS));

endmodule

// File: tb/tb_board_state_mem.sv
// Bench for board_state_mem: directed scenarios plus a randomized run,
// all compared against an array model of the board.
module tb_board_state_mem;

  localparam int CELLS  = 9;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clear = 1'b0;
  logic              we = 1'b0;
  logic [1:0]        data = 2'b00;
  logic [ADDR_W-1:0] addr = '0;
  logic [1:0]        q;
  logic              busy;
  logic [CNT_W-1:0]  n_p1, n_p2, n_tie;
  logic              done;

  int checks = 0;
  int errors = 0;
  logic [1:0] model [1:CELLS];

  board_state_mem #(.CELLS(CELLS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .data(data),
    .addr(addr), .q(q), .busy(busy), .n_p1(n_p1), .n_p2(n_p2),
    .n_tie(n_tie), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_of(input logic [1:0] c);
    int n = 0;
    for (int i = 1; i <= CELLS; i++) if (model[i] == c) n++;
    return n;
  endfunction

  function automatic logic exp_done();
    return (cnt_of(2'b01) + cnt_of(2'b10) + cnt_of(2'b11)) == CELLS;
  endfunction

  task automatic clear_model;
    for (int i = 1; i <= CELLS; i++) model[i] = 2'b00;
  endtask

  task automatic do_write(input int a, input logic [1:0] d);
    addr = ADDR_W'(a);
    data = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    if (a >= 1 && a <= CELLS) model[a] = d;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++; if (q !== 2'b00) begin errors++; $display("FAIL reset_q got %b want 00", q); end
    checks++; if (n_p1 !== 0 || n_p2 !== 0 || n_tie !== 0) begin errors++;
      $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", n_p1, n_p2, n_tie); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    wait_idle(n);
    checks++; if (n + 1 != CELLS + 1) begin errors++; $display("FAIL reset_busy_len got %0d want %0d", n, CELLS); end
    for (int i = 1; i <= CELLS; i++) begin
      addr = ADDR_W'(i);
      tick();
      checks++; if (q !== 2'b00) begin errors++; $display("FAIL reset_read addr %0d got %b want 00", i, q); end
    end
  endtask

  task automatic test_writes;
    do_write(2, 2'b01);
    do_write(5, 2'b10);
    do_write(7, 2'b11);
    checks++; if (n_p1 !== 1 || n_p2 !== 1 || n_tie !== 1) begin errors++;
      $display("FAIL writes_counters got %0d/%0d/%0d want 1/1/1", n_p1, n_p2, n_tie); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL writes_done got %b want 0", done); end
    addr = 4'd5;
    tick();
    checks++; if (q !== 2'b10) begin errors++; $display("FAIL writes_read5 got %b want 10", q); end
  endtask

  task automatic test_overwrite;
    do_write(2, 2'b10);
    checks++; if (n_p1 !== 0 || n_p2 !== 2) begin errors++;
      $display("FAIL overwrite_counters got p1=%0d p2=%0d want 0/2", n_p1, n_p2); end
    checks++; if (q !== 2'b10) begin errors++; $display("FAIL overwrite_q got %b want 10", q); end
    do_write(2, 2'b10);
    checks++; if (n_p1 !== 0 || n_p2 !== 2 || n_tie !== 1) begin errors++;
      $display("FAIL rewrite_counters got %0d/%0d/%0d want 0/2/1", n_p1, n_p2, n_tie); end
  endtask

  task automatic test_bad_addr;
    do_write(0, 2'b01);
    checks++; if (q !== 2'b00) begin errors++; $display("FAIL addr0_q got %b want 00", q); end
    do_write(12, 2'b01);
    checks++; if (q !== 2'b00) begin errors++; $display("FAIL addr12_q got %b want 00", q); end
    checks++; if (n_p1 !== cnt_of(2'b01) || n_p2 !== cnt_of(2'b10) || n_tie !== cnt_of(2'b11)) begin errors++;
      $display("FAIL bad_addr_counters got %0d/%0d/%0d want %0d/%0d/%0d", n_p1, n_p2, n_tie,
               cnt_of(2'b01), cnt_of(2'b10), cnt_of(2'b11)); end
    for (int i = 1; i <= CELLS; i++) begin
      addr = ADDR_W'(i);
      tick();
      checks++; if (q !== model[i]) begin errors++; $display("FAIL bad_addr_mem addr %0d got %b want %b", i, q, model[i]); end
    end
  endtask

  task automatic test_fill_done;
    for (int i = 1; i <= CELLS; i++) begin
      do_write(i, 2'($urandom_range(1, 3)));
      checks++; if (done !== exp_done()) begin errors++;
        $display("FAIL fill_done after addr %0d got %b want %b", i, done, exp_done()); end
    end
    checks++; if (n_p1 !== cnt_of(2'b01) || n_p2 !== cnt_of(2'b10) || n_tie !== cnt_of(2'b11)) begin errors++;
      $display("FAIL fill_counters got %0d/%0d/%0d want %0d/%0d/%0d", n_p1, n_p2, n_tie,
               cnt_of(2'b01), cnt_of(2'b10), cnt_of(2'b11)); end
    do_write(4, 2'b00);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL unfill_done got %b want 0", done); end
    checks++; if (n_p1 !== cnt_of(2'b01) || n_p2 !== cnt_of(2'b10) || n_tie !== cnt_of(2'b11)) begin errors++;
      $display("FAIL unfill_counters got %0d/%0d/%0d want %0d/%0d/%0d", n_p1, n_p2, n_tie,
               cnt_of(2'b01), cnt_of(2'b10), cnt_of(2'b11)); end
  endtask

  task automatic test_clear_restart;
    int n;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    clear_model();
    // writes attempted while busy must be ignored
    we = 1'b1; addr = 4'd6; data = 2'b11;
    tick(); tick(); tick();
    clear = 1'b1; addr = 4'd3; data = 2'b01;
    tick();
    clear = 1'b0; we = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
    checks++; if (n_p1 !== 0 || n_p2 !== 0 || n_tie !== 0) begin errors++;
      $display("FAIL restart_counters got %0d/%0d/%0d want 0/0/0", n_p1, n_p2, n_tie); end
    wait_idle(n);
    checks++; if (n != CELLS) begin errors++; $display("FAIL restart_busy_len got %0d want %0d", n, CELLS); end
    for (int i = 1; i <= CELLS; i++) begin
      addr = ADDR_W'(i);
      tick();
      checks++; if (q !== 2'b00) begin errors++; $display("FAIL restart_read addr %0d got %b want 00", i, q); end
    end
    checks++; if (n_p1 !== 0 || n_p2 !== 0 || n_tie !== 0 || done !== 1'b0) begin errors++;
      $display("FAIL restart_final got %0d/%0d/%0d done=%b want 0/0/0 done=0", n_p1, n_p2, n_tie, done); end
  endtask

  task automatic test_random;
    int a;
    logic [1:0] d, eq;
    logic w;
    for (int k = 0; k < 300; k++) begin
      a = $urandom_range(0, 15);
      d = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      addr = ADDR_W'(a); data = d; we = w;
      tick();
      we = 1'b0;
      if (w && a >= 1 && a <= CELLS) model[a] = d;
      eq = (a >= 1 && a <= CELLS) ? model[a] : 2'b00;
      checks++; if (q !== eq) begin errors++; $display("FAIL rand_q iter %0d addr %0d got %b want %b", k, a, q, eq); end
      checks++; if (n_p1 !== cnt_of(2'b01) || n_p2 !== cnt_of(2'b10) || n_tie !== cnt_of(2'b11)) begin errors++;
        $display("FAIL rand_counters iter %0d got %0d/%0d/%0d want %0d/%0d/%0d", k, n_p1, n_p2, n_tie,
                 cnt_of(2'b01), cnt_of(2'b10), cnt_of(2'b11)); end
      checks++; if (done !== exp_done()) begin errors++; $display("FAIL rand_done iter %0d got %b want %b", k, done, exp_done()); end
    end
  endtask

  initial begin
    clear_model();
    tick();
    test_reset();
    test_writes();
    test_overwrite();
    test_bad_addr();
    test_fill_done();
    test_clear_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
